param_seq_detector: RTL and testbench

Runtime-configurable serial bit-pattern detector. It is the parametrised successor to the team's fixed 4-bit "1011" detector FSM. Pattern, pattern length (1..MAX_LEN) and overlap mode are loaded at run time, and input bits are qualified by a valid strobe. A registered match pulse and a saturating match counter feed downstream protocol-framing and debug logic.

---
 rtl/param_seq_detector_if.sv | 38 +++
 rtl/param_seq_detector.sv | 117 +++++++++++
 tb/tb_param_seq_detector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/param_seq_detector_if.sv
// ============================================================================
//  Module   : param_seq_detector_if
//  Purpose  : Configuration, serial-data and status bundle for the detector.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface param_seq_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
    logic               cfg_load_i;
    logic [MAX_LEN-1:0] cfg_pattern_i;
    logic [LEN_W-1:0]   cfg_len_i;
    logic               cfg_overlap_i;
    logic               data_valid_i;
    logic               data_in_i;
    logic               cnt_clr_i;
    logic               detected_o;
    logic [CNT_W-1:0]   match_count_o;
    logic               armed_o;
    logic               cfg_err_o;

    modport master (
        output cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
        output data_valid_i, data_in_i, cnt_clr_i,
        input  detected_o, match_count_o, armed_o, cfg_err_o
    );

    modport slave (
        input  cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
        input  data_valid_i, data_in_i, cnt_clr_i,
        output detected_o, match_count_o, armed_o, cfg_err_o
    );
endinterface

`default_nettype wire

// File: rtl/param_seq_detector.sv
// ============================================================================
//  Module   : param_seq_detector
//  Purpose  : Run-time configurable serial pattern detector with match counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_seq_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    param_seq_detector_if.slave  bus
);
    typedef enum logic [0:0] {
        S_UNCFG = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] c_MAX_FILL = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               w_accept;
    logic               w_legal;
    logic [MAX_LEN-1:0] w_nh;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_enough;
    logic               w_match;

    assign w_legal  = (bus.cfg_len_i != '0) && (bus.cfg_len_i <= c_MAX_FILL);
    assign w_accept = (state_q == S_ARMED) && bus.data_valid_i && !bus.cfg_load_i;
    assign w_nh     = {hist_q[MAX_LEN-2:0], bus.data_in_i};
    // Only the low len bits take part; len_q is legal whenever armed.
    assign w_mask   = {MAX_LEN{1'b1}} >> (c_MAX_FILL - len_q);
    assign w_enough = ({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q};
    assign w_match  = w_accept && w_enough && ((w_nh & w_mask) == (pat_q & w_mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        det_d   = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (bus.cfg_load_i) begin
            pat_d   = bus.cfg_pattern_i;
            len_d   = bus.cfg_len_i;
            ovl_d   = bus.cfg_overlap_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = w_legal ? S_ARMED : S_UNCFG;
            err_d   = !w_legal;
        end else if (w_accept) begin
            hist_d = w_nh;
            det_d  = w_match;
            if (w_match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != c_MAX_FILL) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end

        // A clear coinciding with a match leaves that match counted.
        if (bus.cnt_clr_i) begin
            cnt_d = w_match ? CNT_W'(1) : '0;
        end else if (w_match && (cnt_q != c_CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.detected_o    = det_q;
    assign bus.match_count_o = cnt_q;
    assign bus.armed_o       = (state_q == S_ARMED);
    assign bus.cfg_err_o     = err_q;
endmodule

`default_nettype wire

// File: tb/tb_param_seq_detector.sv
// ============================================================================
//  Module   : tb_param_seq_detector
//  Purpose  : Directed self-checking bench for param_seq_detector.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_seq_detector;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_seq_detector_if #(.MAX_LEN(8), .CNT_W(8)) if_a ();
    param_seq_detector_if #(.MAX_LEN(8), .CNT_W(2)) if_b ();

    param_seq_detector #(.MAX_LEN(8), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    param_seq_detector #(.MAX_LEN(8), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        if_a.cfg_pattern_i = pat;
        if_a.cfg_len_i     = len;
        if_a.cfg_overlap_i = ovl;
        if_a.cfg_load_i    = 1'b1;
        cyc();
        if_a.cfg_load_i    = 1'b0;
    endtask

    // Bit i of bits is sent i-th; bit i of exp_det is the pulse expected after it.
    task automatic stream_a(input string tag, input int n, input logic [15:0] bits,
                            input logic [15:0] exp_det);
        for (int i = 0; i < n; i++) begin
            if_a.data_valid_i = 1'b1;
            if_a.data_in_i    = bits[i];
            cyc();
            if_a.data_valid_i = 1'b0;
            check($sformatf("%s_det%0d", tag, i), {31'd0, if_a.detected_o}, {31'd0, exp_det[i]});
        end
    endtask

    task automatic idle_a(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if_a.data_valid_i = 1'b0;
            if_a.data_in_i    = 1'b1;
            cyc();
            check($sformatf("%s_idle%0d", tag, i), {31'd0, if_a.detected_o}, 32'd0);
        end
    endtask

    initial begin
        if_a.cfg_load_i = 1'b0; if_a.cfg_pattern_i = '0; if_a.cfg_len_i = '0;
        if_a.cfg_overlap_i = 1'b0; if_a.data_valid_i = 1'b0; if_a.data_in_i = 1'b0;
        if_a.cnt_clr_i = 1'b0;
        if_b.cfg_load_i = 1'b0; if_b.cfg_pattern_i = '0; if_b.cfg_len_i = '0;
        if_b.cfg_overlap_i = 1'b0; if_b.data_valid_i = 1'b0; if_b.data_in_i = 1'b0;
        if_b.cnt_clr_i = 1'b0;

        cyc(); cyc();
        reset = 1'b0;
        check("rst_det",   {31'd0, if_a.detected_o}, 32'd0);
        check("rst_cnt",   {24'd0, if_a.match_count_o}, 32'd0);
        check("rst_armed", {31'd0, if_a.armed_o}, 32'd0);
        check("rst_err",   {31'd0, if_a.cfg_err_o}, 32'd0);

        // Data before any load is ignored.
        stream_a("uncfg", 2, 16'b11, 16'b00);

        // Saturating 2-bit counter with len 1 pattern 1.
        if_b.cfg_pattern_i = 8'h01; if_b.cfg_len_i = 4'd1; if_b.cfg_overlap_i = 1'b1;
        if_b.cfg_load_i = 1'b1;
        cyc();
        if_b.cfg_load_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_b.data_valid_i = 1'b1;
            if_b.data_in_i    = 1'b1;
            cyc();
            check($sformatf("sat_cnt%0d", i), {30'd0, if_b.match_count_o},
                  (i < 3) ? 32'(i + 1) : 32'd3);
        end
        if_b.cnt_clr_i = 1'b1;
        cyc();
        check("clr_with_match", {30'd0, if_b.match_count_o}, 32'd1);
        if_b.data_valid_i = 1'b0;
        cyc();
        check("clr_no_match", {30'd0, if_b.match_count_o}, 32'd0);
        if_b.cnt_clr_i = 1'b0;

        // Overlapping 1011.
        load_a(8'b1011, 4'd4, 1'b1);
        check("ov_armed", {31'd0, if_a.armed_o}, 32'd1);
        check("ov_err",   {31'd0, if_a.cfg_err_o}, 32'd0);
        stream_a("ov", 7, 16'b1101101, 16'b1001000);
        check("ov_cnt", {24'd0, if_a.match_count_o}, 32'd2);

        if_a.cnt_clr_i = 1'b1;
        cyc();
        if_a.cnt_clr_i = 1'b0;
        check("clr_cnt", {24'd0, if_a.match_count_o}, 32'd0);

        // Non-overlapping 1011.
        load_a(8'b1011, 4'd4, 1'b0);
        stream_a("nov1", 7, 16'b1101101, 16'b0001000);
        check("nov1_cnt", {24'd0, if_a.match_count_o}, 32'd1);
        load_a(8'b1011, 4'd4, 1'b0);
        stream_a("nov2", 8, 16'b11011101, 16'b10001000);
        check("nov2_cnt", {24'd0, if_a.match_count_o}, 32'd3);

        // Gaps in data_valid, pattern 110.
        load_a(8'b110, 4'd3, 1'b1);
        stream_a("gap_a", 1, 16'b1, 16'b0);
        idle_a("gap_a", 2);
        stream_a("gap_b", 1, 16'b1, 16'b0);
        idle_a("gap_b", 2);
        stream_a("gap_c", 1, 16'b0, 16'b1);
        idle_a("gap_c", 1);

        // History before a reload never contributes.
        load_a(8'b1011, 4'd4, 1'b1);
        stream_a("pre", 3, 16'b101, 16'b000);
        load_a(8'b1011, 4'd4, 1'b1);
        stream_a("post", 1, 16'b1, 16'b0);

        // Illegal length.
        load_a(8'hFF, 4'd0, 1'b1);
        check("len0_err",   {31'd0, if_a.cfg_err_o}, 32'd1);
        check("len0_armed", {31'd0, if_a.armed_o}, 32'd0);
        stream_a("len0", 4, 16'b1111, 16'b0000);
        load_a(8'hFF, 4'd9, 1'b1);
        check("len9_err", {31'd0, if_a.cfg_err_o}, 32'd1);

        load_a(8'b1, 4'd1, 1'b1);
        check("len1_err",   {31'd0, if_a.cfg_err_o}, 32'd0);
        check("len1_armed", {31'd0, if_a.armed_o}, 32'd1);
        stream_a("len1", 3, 16'b111, 16'b111);

        // cfg_load wins over a same-cycle data bit.
        if_a.cfg_load_i   = 1'b1;
        if_a.data_valid_i = 1'b1;
        if_a.data_in_i    = 1'b1;
        cyc();
        if_a.cfg_load_i   = 1'b0;
        if_a.data_valid_i = 1'b0;
        check("prio_det", {31'd0, if_a.detected_o}, 32'd0);
        stream_a("prio_next", 1, 16'b1, 16'b1);

        // Reset mid-pattern.
        load_a(8'b1011, 4'd4, 1'b1);
        stream_a("rsm", 3, 16'b101, 16'b000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rsm_det",   {31'd0, if_a.detected_o}, 32'd0);
        check("rsm_cnt",   {24'd0, if_a.match_count_o}, 32'd0);
        check("rsm_armed", {31'd0, if_a.armed_o}, 32'd0);
        check("rsm_err",   {31'd0, if_a.cfg_err_o}, 32'd0);
        stream_a("rsm_noload", 1, 16'b1, 16'b0);
        load_a(8'b1011, 4'd4, 1'b1);
        stream_a("rsm_reload", 4, 16'b1101, 16'b1000);
        check("rsm_cnt2", {24'd0, if_a.match_count_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
